// File: rtl/mem_controller.sv
// Memory-controller responder: stores an input burst into a local RAM and streams it out in
// CHUNK-word groups to a processing register. Define MC_PARITY_EN for per-word even parity.
module mem_controller #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned CHUNK  = 4
) (
  input  logic                    mc_clk,
  input  logic                    mc_reset,
  input  logic [2:0]              mc_data_contition,
  input  logic [5:0]              mc_data_length,
  input  logic [DATA_W-1:0]       mc_data_in,
  input  logic                    mc_data_in_valid,
  input  logic                    mc_procc_done,
  output logic                    mc_done,
  output logic                    mc_data_done,
  output logic [DATA_W*CHUNK-1:0] mc_reg_data,
  output logic                    mc_reg_valid,
  output logic                    mc_parity_err
);

  localparam logic [2:0] CmdNone  = 3'b000;
  localparam logic [2:0] CmdStore = 3'b100;
  localparam logic [2:0] CmdLoad  = 3'b010;
  localparam logic [2:0] CmdProc  = 3'b001;

  localparam int unsigned LaneW = $clog2(CHUNK + 1);

`ifdef MC_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StStore,
    StLoad,
    StWaitCmd,
    StProc
  } state_e;

  state_e                  state_q, state_d;
  logic [5:0]              wr_ptr_q, wr_ptr_d;
  logic [5:0]              rd_ptr_q, rd_ptr_d;
  logic [5:0]              len_q, len_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [LaneW-1:0]        iss_q, iss_d;
  logic [LaneW-1:0]        lane_q, lane_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [DATA_W*CHUNK-1:0] reg_data_q, reg_data_d;

  logic [MemW-1:0]         mem_q [DEPTH];
  logic [MemW-1:0]         rd_word_q;
  logic [MemW-1:0]         mem_wdata;
  logic                    mem_we, mem_re;

  logic                    store_entry, load_entry;
  logic                    chunk_full, data_empty, load_fin;

  assign chunk_full  = (iss_q == LaneW'(CHUNK));
  assign data_empty  = (rd_ptr_q == len_q);
  // A LOAD finishes once no read is in flight and nothing more may be issued for this chunk.
  assign load_fin    = (state_q == StLoad) && !rd_pend_q && (chunk_full || data_empty);
  assign store_entry = (state_d == StStore) && (state_q != StStore);
  assign load_entry  = (state_d == StLoad) && (state_q != StLoad);

  // State register
  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (mc_data_contition == CmdStore) begin
          state_d = StStore;
        end else if (mc_data_contition == CmdLoad) begin
          state_d = StLoad;
        end
      end
      StStore: begin
        if (wr_ptr_q == len_q) begin
          state_d = StWaitCmd;
        end
      end
      StLoad: begin
        if (load_fin) begin
          state_d = StWaitCmd;
        end
      end
      StWaitCmd: begin
        // The core still shows the command just served until the cycle after mc_done.
        if (mc_data_contition != cmd_q) begin
          case (mc_data_contition)
            CmdStore: state_d = StStore;
            CmdLoad:  state_d = StLoad;
            CmdProc:  state_d = StProc;
            default:  state_d = StIdle;
          endcase
        end
      end
      StProc: begin
        case (mc_data_contition)
          CmdNone:  state_d = StIdle;
          CmdLoad:  state_d = StLoad;
          CmdProc:  state_d = StProc;
          CmdStore: state_d = StProc;
          default:  state_d = StIdle;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: pointers, length latch, read pipeline and lane capture
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    iss_d      = iss_q;
    lane_d     = lane_q;
    rd_pend_d  = rd_pend_q;
    reg_data_d = reg_data_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    if (store_entry) begin
      len_d    = mc_data_length;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cmd_d    = CmdStore;
    end

    if ((state_q == StStore) && mc_data_in_valid && (wr_ptr_q != len_q)) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 6'd1;
    end

    if (load_entry) begin
      reg_data_d = '0;
      iss_d      = '0;
      rd_pend_d  = 1'b0;
      cmd_d      = CmdLoad;
    end

    if (state_q == StLoad) begin
      rd_pend_d = 1'b0;
      if (!chunk_full && !data_empty) begin
        mem_re    = 1'b1;
        rd_ptr_d  = rd_ptr_q + 6'd1;
        iss_d     = iss_q + LaneW'(1);
        lane_d    = iss_q;
        rd_pend_d = 1'b1;
      end
      // RAM data issued last cycle lands in the lane recorded alongside it.
      if (rd_pend_q) begin
        for (int k = 0; k < CHUNK; k++) begin
          if (lane_q == LaneW'(k)) begin
            reg_data_d[k*DATA_W +: DATA_W] = rd_word_q[DATA_W-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      cmd_q      <= CmdNone;
      iss_q      <= '0;
      lane_q     <= '0;
      rd_pend_q  <= 1'b0;
      reg_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      iss_q      <= iss_d;
      lane_q     <= lane_d;
      rd_pend_q  <= rd_pend_d;
      reg_data_q <= reg_data_d;
    end
  end

  // Synchronous RAM, contents deliberately not reset
  always_ff @(posedge mc_clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= mem_wdata;
    end
    if (mem_re) begin
      rd_word_q <= mem_q[rd_ptr_q];
    end
  end

`ifdef MC_PARITY_EN
  logic perr_q, perr_d;

  assign mem_wdata = {^mc_data_in, mc_data_in};

  // Stored word plus its even-parity bit must XOR to zero.
  always_comb begin
    perr_d = perr_q;
    if (store_entry) begin
      perr_d = 1'b0;
    end else if ((state_q == StLoad) && rd_pend_q && (^rd_word_q)) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign mc_parity_err = perr_q;
`else
  assign mem_wdata     = mc_data_in;
  assign mc_parity_err = 1'b0;
`endif

  // Output logic
  always_comb begin
    mc_done      = ((state_q == StStore) && (wr_ptr_q == len_q)) || load_fin;
    mc_reg_valid = load_fin;
    mc_reg_data  = reg_data_q;
    mc_data_done = (state_q == StProc) && (mc_data_contition == CmdProc) && data_empty &&
                   mc_procc_done;
  end

  wr_ptr_bound_a: assert property (@(posedge mc_clk) disable iff (mc_reset) wr_ptr_q <= len_q);
  rd_ptr_bound_a: assert property (@(posedge mc_clk) disable iff (mc_reset) rd_ptr_q <= len_q);
  reg_valid_a:    assert property (@(posedge mc_clk) disable iff (mc_reset)
                                   mc_reg_valid |-> mc_done);

endmodule
